// File: rtl/lc3_writeback_pkg.sv
// Shared types and constants for the LC-3 writeback stage.
// Writeback source encodings, condition-code values and register-file geometry.
package lc3_writeback_pkg;

  localparam int unsigned REG_W    = 16;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC  = 2'd1,
    WB_MEM = 2'd2,
    WB_NPC = 2'd3
  } wb_sel_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  function automatic logic [2:0] psr_of(input logic [REG_W-1:0] value);
    if (value[REG_W-1])   return PSR_N;
    else if (value == '0) return PSR_Z;
    else                  return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 register file: one synchronous write port, two asynchronous read ports.
// All registers, R0 included, are writable and clear on reset.
module lc3_regfile
  import lc3_writeback_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [2:0]       raddr1,
  input  logic [2:0]       raddr2,
  output logic [REG_W-1:0] rdata1,
  output logic [REG_W-1:0] rdata2
);

  logic [REG_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: source select, register file update and NZP condition codes.
// Define LC3_WB_BYPASS_EN to forward same-cycle write data onto VSR1/VSR2.
module lc3_writeback
  import lc3_writeback_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_writeback,
  input  logic [REG_W-1:0] aluout_in,
  input  logic [REG_W-1:0] memout,
  input  logic [REG_W-1:0] pcout_in,
  input  logic [REG_W-1:0] npc,
  input  logic [1:0]       W_control,
  input  logic [2:0]       dr,
  input  logic [2:0]       sr1,
  input  logic [2:0]       sr2,
  output logic [REG_W-1:0] VSR1,
  output logic [REG_W-1:0] VSR2,
  output logic [2:0]       psr
);

  wb_sel_e          sel;
  logic [REG_W-1:0] wdata;
  logic [REG_W-1:0] rd1, rd2;
  logic [2:0]       psr_d, psr_q;

  assign sel = wb_sel_e'(W_control);

  always_comb begin
    wdata = aluout_in;
    case (sel)
      WB_ALU:  wdata = aluout_in;
      WB_PC:   wdata = pcout_in;
      WB_MEM:  wdata = memout;
      WB_NPC:  wdata = npc;
      default: wdata = aluout_in;
    endcase
  end

  always_comb begin
    psr_d = psr_q;
    if (enable_writeback) psr_d = psr_of(wdata);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) psr_q <= '0;
    else        psr_q <= psr_d;
  end

  assign psr = psr_q;

  lc3_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (enable_writeback),
    .waddr  (dr),
    .wdata  (wdata),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

`ifdef LC3_WB_BYPASS_EN
  // Forward pending write data so a reader of dr sees it before the edge.
  always_comb begin
    VSR1 = rd1;
    VSR2 = rd2;
    if (enable_writeback && (sr1 == dr)) VSR1 = wdata;
    if (enable_writeback && (sr2 == dr)) VSR2 = wdata;
  end
`else
  assign VSR1 = rd1;
  assign VSR2 = rd2;
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed cases plus randomized traffic
// against an array-based reference model of the register file and condition codes.
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [15:0] aluout_in = '0, memout = '0, pcout_in = '0, npc = '0;
  logic [1:0]  W_control = '0;
  logic [2:0]  dr = '0, sr1 = '0, sr2 = '0;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [8];
  logic [2:0]  psr_m;

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .aluout_in        (aluout_in),
    .memout           (memout),
    .pcout_in         (pcout_in),
    .npc              (npc),
    .W_control        (W_control),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] src_value(input logic [1:0] wc, input logic [15:0] alu,
                                            input logic [15:0] pc, input logic [15:0] mem,
                                            input logic [15:0] np);
    logic [15:0] cand [4];
    cand[0] = alu; cand[1] = pc; cand[2] = mem; cand[3] = np;
    return cand[wc];
  endfunction

  function automatic logic [2:0] nzp(input logic [15:0] v);
    if (v >= 16'h8000) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] read_exp(input logic [2:0] idx, input logic en,
                                           input logic [2:0] d, input logic [15:0] wv);
`ifdef LC3_WB_BYPASS_EN
    if (en && idx == d) return wv;
`endif
    return model[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    psr_m = 3'b000;
  endtask

  // One cycle: drive on the falling edge, check reads before and after the rising edge.
  task automatic apply(input string tag, input logic en, input logic [1:0] wc,
                       input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [15:0] alu, input logic [15:0] pc,
                       input logic [15:0] mem, input logic [15:0] np);
    logic [15:0] wv;
    @(negedge clock);
    enable_writeback = en; W_control = wc; dr = d; sr1 = s1; sr2 = s2;
    aluout_in = alu; pcout_in = pc; memout = mem; npc = np;
    wv = src_value(wc, alu, pc, mem, np);
    #1;
    chk({tag, ".vsr1_pre"}, VSR1, read_exp(s1, en, d, wv));
    chk({tag, ".vsr2_pre"}, VSR2, read_exp(s2, en, d, wv));
    @(posedge clock);
    if (en) begin
      model[d] = wv;
      psr_m    = nzp(wv);
    end
    #1;
    chk({tag, ".psr"},       {13'b0, psr}, {13'b0, psr_m});
    chk({tag, ".vsr1_post"}, VSR1, model[s1]);
    chk({tag, ".vsr2_post"}, VSR2, model[s2]);
  endtask

  initial begin
    model_reset();

    // Reset state
    #3;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i); #1;
      chk("reset.vsr1", VSR1, 16'h0000);
      chk("reset.vsr2", VSR2, 16'h0000);
    end
    chk("reset.psr", {13'b0, psr}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // Enable gating
    apply("gate", 1'b0, 2'd0, 3'd5, 3'd5, 3'd5, 16'hFFFF, 16'h0, 16'h0, 16'h0);

    // Source select sweep into R3
    for (int w = 0; w < 4; w++)
      apply("srcsel", 1'b1, 2'(w), 3'd3, 3'd3, 3'd0,
            16'h1234, 16'h9ABC, 16'h5678, 16'hDEF0);

    // Condition codes, then hold with enable low
    apply("psr_n", 1'b1, 2'd0, 3'd1, 3'd1, 3'd3, 16'h8000, 16'h0, 16'h0, 16'h0);
    apply("psr_z", 1'b1, 2'd0, 3'd1, 3'd1, 3'd3, 16'h0000, 16'h0, 16'h0, 16'h0);
    apply("psr_p", 1'b1, 2'd0, 3'd1, 3'd1, 3'd3, 16'h0001, 16'h0, 16'h0, 16'h0);
    apply("psr_hold", 1'b0, 2'd0, 3'd1, 3'd1, 3'd3, 16'h8000, 16'h0, 16'h0, 16'h0);
    chk("psr_hold.value", {13'b0, psr}, 16'h0001);

    // Read during write on R2
    apply("rdw_init", 1'b1, 2'd0, 3'd2, 3'd0, 3'd0, 16'h0011, 16'h0, 16'h0, 16'h0);
    apply("rdw", 1'b1, 2'd0, 3'd2, 3'd2, 3'd2, 16'h0022, 16'h0, 16'h0, 16'h0);
    chk("rdw.next", VSR1, 16'h0022);

    // Full sweep: every register, every read pair
    for (int i = 0; i < 8; i++)
      apply("sweep_wr", 1'b1, 2'd2, 3'(i), 3'(i), 3'd0, 16'h0, 16'h0, 16'h1000 + 16'(i), 16'h0);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        apply("sweep_rd", 1'b0, 2'd0, 3'd0, 3'(a), 3'(b), 16'hAAAA, 16'h0, 16'h0, 16'h0);

    // Mid-run asynchronous reset, with a write held active across an edge
    @(negedge clock);
    enable_writeback = 1'b1; W_control = 2'd0; dr = 3'd4; aluout_in = 16'h7777;
    #2 reset = 1'b0;
    model_reset();
    #1 chk("midreset.psr", {13'b0, psr}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(i); #1;
      chk("midreset.vsr1", VSR1, 16'h0000);
      chk("midreset.vsr2", VSR2, 16'h0000);
    end
    @(posedge clock); #1;
    sr1 = 3'd4; #1;
    chk("midreset.discard", VSR1, 16'h0000);
    chk("midreset.psr2", {13'b0, psr}, 16'h0000);
    @(negedge clock);
    enable_writeback = 1'b0;
    reset = 1'b1;
    apply("first_write", 1'b1, 2'd3, 3'd0, 3'd0, 3'd4, 16'h0, 16'h0, 16'h0, 16'h8001);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++)
      apply("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), 16'($urandom_range(0, 2) == 0 ? 0 : $urandom),
            16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no completion expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
